// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issuer: opcode encoding, datapath width and
// the opcode legality rule used to flag illegal requests.
package alu_pkg;

    localparam int ALU_W = 32;
    localparam int CMD_W = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_AND = 4'b0000,
        CMD_OR  = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_SHL = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SHR = 4'b0101,
        CMD_MUL = 4'b0110,
        CMD_XOR = 4'b0111,
        CMD_SLT = 4'b1000
    } alu_cmd_e;

    // Opcodes are dense from AND up to SLT; everything above is unassigned.
    function automatic logic is_legal_cmd(input logic [CMD_W-1:0] cmd);
        return (cmd <= CMD_SLT);
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO with asynchronous active-low clear and occupancy
// count. Storage is not cleared; only pointers and count are.
module alu_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign do_push   = push && (count != CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/alu_issuer.sv
// Front end for the 32-bit ALU: issues tagged requests, tracks the ALU's
// one-cycle result latency and returns in-order tagged responses.
module alu_issuer
    import alu_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ALU_W-1:0]  req_in1,
    input  logic [ALU_W-1:0]  req_in2,
    input  logic [CMD_W-1:0]  req_cmd,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              alu_reset,
    output logic [ALU_W-1:0]  alu_in1,
    output logic [ALU_W-1:0]  alu_in2,
    output logic [CMD_W-1:0]  alu_cmd,
    input  logic [ALU_W-1:0]  alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ALU_W-1:0]  rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err
);

    localparam int CNT_W   = $clog2(RSP_DEPTH) + 1;
    localparam int ENTRY_W = 1 + TAG_W + ALU_W;

    logic              fire;
    logic              vld_p1;
    logic              vld_p2;
    logic [TAG_W-1:0]  tag_p1;
    logic [TAG_W-1:0]  tag_p2;
    logic              err_p1;
    logic              err_p2;
    logic [1:0]        inflight;
    logic [CNT_W:0]    credits_used;
    logic [CNT_W-1:0]  q_count;
    logic              q_empty;
    logic              rsp_pop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Illegal requests leave the ALU result stale, so their payload is forced to zero.
    function automatic logic [ALU_W-1:0] mask_result(input logic err, input logic [ALU_W-1:0] res);
        return err ? '0 : res;
    endfunction

    // Every accepted request owns a queue slot from issue until it is popped,
    // which is what makes a push into the queue unable to overflow.
    assign inflight     = {1'b0, vld_p1} + {1'b0, vld_p2};
    assign credits_used = (CNT_W + 1)'(q_count) + (CNT_W + 1)'(inflight);
    assign req_ready    = !alu_reset && (credits_used < (CNT_W + 1)'(RSP_DEPTH));
    assign fire         = req_valid && req_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_reset <= 1'b1;
        end else begin
            alu_reset <= 1'b0;
        end
    end

    // Stage p0: drive the ALU inputs; they hold their last values when idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_in1 <= '0;
            alu_in2 <= '0;
            alu_cmd <= '0;
        end else if (fire) begin
            alu_in1 <= req_in1;
            alu_in2 <= req_in2;
            alu_cmd <= req_cmd;
        end
    end

    // Stages p1/p2: control valids follow the ALU's registered latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= fire;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clock) begin
        if (fire) begin
            tag_p1 <= req_tag;
            err_p1 <= !is_legal_cmd(req_cmd);
        end
        tag_p2 <= tag_p1;
        err_p2 <= err_p1;
    end

    // Stage p2 -> queue: alu_result now holds the result for the p2 entry.
    assign push_entry = {err_p2, tag_p2, mask_result(err_p2, alu_result)};
    assign rsp_pop    = rsp_valid && rsp_ready;

    alu_rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (vld_p2),
        .push_data (push_entry),
        .pop       (rsp_pop),
        .head_data (head_entry),
        .count     (q_count),
        .empty     (q_empty)
    );

    assign rsp_valid = !q_empty;
    assign {rsp_err, rsp_tag, rsp_result} = q_empty ? '0 : head_entry;

endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench for alu_issuer: behavioural ALU, queue-based reference
// model compared every cycle, directed scenarios and randomized traffic.
module tb_alu_issuer;
    import alu_pkg::*;

    localparam int TAG_W     = 4;
    localparam int RSP_DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_in1;
    logic [31:0]       req_in2;
    logic [3:0]        req_cmd;
    logic [TAG_W-1:0]  req_tag;
    logic              alu_reset;
    logic [31:0]       alu_in1;
    logic [31:0]       alu_in2;
    logic [3:0]        alu_cmd;
    logic [31:0]       alu_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_result;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               due;
    } exp_t;

    exp_t        model_q[$];
    exp_t        log_q[$];
    int          edge_cnt      = 0;
    int          fire_cnt      = 0;
    logic        exp_alu_reset = 1'b1;
    logic [31:0] last_in1      = '0;
    logic [31:0] last_in2      = '0;
    logic [3:0]  last_cmd      = '0;

    alu_issuer #(.TAG_W(TAG_W), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_cmd    (req_cmd),
        .req_tag    (req_tag),
        .alu_reset  (alu_reset),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_cmd    (alu_cmd),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] alu_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] r;
        sa = a;
        sb = b;
        case (cmd)
            CMD_AND: r = a & b;
            CMD_OR:  r = a | b;
            CMD_ADD: r = a + b;
            CMD_SHL: r = a << b[4:0];
            CMD_SUB: r = a - b;
            CMD_SHR: r = a >> b[4:0];
            CMD_MUL: r = a * b;
            CMD_XOR: r = a ^ b;
            CMD_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return r;
    endfunction

    // The ALU being driven: registered result, synchronous reset, holds on illegal opcodes.
    always @(posedge clock) begin
        if (alu_reset) begin
            alu_result <= '0;
        end else if (is_legal_cmd(alu_cmd)) begin
            alu_result <= alu_op(alu_cmd, alu_in1, alu_in2);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted request is one entry that becomes visible
    // two edges after acceptance and leaves on a handshake; outstanding entries
    // never exceed the queue depth.
    always @(negedge clock) begin
        logic exp_ready;
        logic exp_valid;
        logic legal;
        exp_t e;
        if (!reset_n) begin
            model_q.delete();
            exp_alu_reset = 1'b1;
            last_in1 = '0;
            last_in2 = '0;
            last_cmd = '0;
            check("rst_alu_reset", alu_reset, 1);
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_fields", {rsp_err, rsp_tag, rsp_result}, 0);
            check("rst_alu_inputs", {alu_cmd, alu_in1, alu_in2}, 0);
        end else begin
            exp_ready = !exp_alu_reset && (model_q.size() < RSP_DEPTH);
            exp_valid = (model_q.size() > 0) && (model_q[0].due <= edge_cnt);
            check("alu_reset", alu_reset, exp_alu_reset);
            check("req_ready", req_ready, exp_ready);
            check("rsp_valid", rsp_valid, exp_valid);
            check("alu_in1", alu_in1, last_in1);
            check("alu_in2", alu_in2, last_in2);
            check("alu_cmd", alu_cmd, last_cmd);
            if (exp_valid) begin
                check("rsp_result", rsp_result, model_q[0].res);
                check("rsp_tag", rsp_tag, model_q[0].tag);
                check("rsp_err", rsp_err, model_q[0].err);
            end
            if (exp_valid && rsp_ready) begin
                log_q.push_back(model_q[0]);
                void'(model_q.pop_front());
            end
            if (req_valid && exp_ready) begin
                legal = (req_cmd <= 4'd8);
                e.res = legal ? alu_op(req_cmd, req_in1, req_in2) : 32'h0;
                e.tag = req_tag;
                e.err = !legal;
                e.due = edge_cnt + 3;
                model_q.push_back(e);
                last_in1 = req_in1;
                last_in2 = req_in2;
                last_cmd = req_cmd;
                fire_cnt++;
            end
            exp_alu_reset = 1'b0;
        end
        edge_cnt++;
    end

    task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        logic acc;
        acc = 1'b0;
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_in1   = a;
        req_in2   = b;
        req_tag   = tag;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clock);
            acc = req_ready;
            @(posedge clock);
            #1;
        end
        check("send_accepted", acc, 1);
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 60 && log_q.size() < n; i++) begin
            @(posedge clock);
            #1;
        end
        check("log_size", log_q.size(), n);
    endtask

    task automatic chk_log(input int idx, input logic [31:0] res, input logic [TAG_W-1:0] tag, input logic err);
        if (idx < log_q.size()) begin
            check("log_result", log_q[idx].res, res);
            check("log_tag", log_q[idx].tag, tag);
            check("log_err", log_q[idx].err, err);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int accepted;
        int k;
        logic acc;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_in1   = '0;
        req_in2   = '0;
        req_cmd   = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        check("release_alu_reset_held", alu_reset, 1);
        check("release_req_ready_low", req_ready, 0);
        cycles(2);

        // Single ADD with explicit two-cycle latency.
        rsp_ready = 1'b1;
        base = log_q.size();
        send(CMD_ADD, 32'd5, 32'd7, 4'd3);
        req_valid = 1'b0;
        check("add_lat0_valid", rsp_valid, 0);
        cycles(1);
        check("add_lat1_valid", rsp_valid, 0);
        cycles(1);
        check("add_lat2_valid", rsp_valid, 1);
        check("add_result", rsp_result, 32'd12);
        check("add_tag", rsp_tag, 4'd3);
        check("add_err", rsp_err, 0);
        wait_log(base + 1);
        chk_log(base, 32'd12, 4'd3, 1'b0);

        // Back-to-back issue.
        base = log_q.size();
        send(CMD_SUB, 32'd10, 32'd3, 4'd1);
        send(CMD_SLT, 32'd2, 32'd9, 4'd2);
        send(CMD_SHL, 32'd1, 32'd4, 4'd3);
        send(CMD_MUL, 32'd6, 32'd7, 4'd4);
        req_valid = 1'b0;
        wait_log(base + 4);
        chk_log(base + 0, 32'd7, 4'd1, 1'b0);
        chk_log(base + 1, 32'd1, 4'd2, 1'b0);
        chk_log(base + 2, 32'd16, 4'd3, 1'b0);
        chk_log(base + 3, 32'd42, 4'd4, 1'b0);

        // Illegal opcode between two ORs keeps its place in order.
        base = log_q.size();
        send(CMD_OR, 32'hF0, 32'h0F, 4'd8);
        send(4'b1010, 32'd3, 32'd4, 4'd9);
        send(CMD_OR, 32'hF0, 32'h0F, 4'd10);
        req_valid = 1'b0;
        wait_log(base + 3);
        chk_log(base + 0, 32'hFF, 4'd8, 1'b0);
        chk_log(base + 1, 32'h0, 4'd9, 1'b1);
        chk_log(base + 2, 32'hFF, 4'd10, 1'b0);

        // Backpressure: only RSP_DEPTH requests fit, then drain.
        cycles(2);
        rsp_ready = 1'b0;
        base = log_q.size();
        accepted = 0;
        k = 0;
        req_valid = 1'b1;
        req_cmd = CMD_ADD;
        req_in1 = 32'd100;
        req_in2 = 32'd0;
        req_tag = 4'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            acc = req_ready;
            @(posedge clock);
            #1;
            if (acc) begin
                accepted++;
                k++;
                req_in2 = 32'(k);
                req_tag = TAG_W'(k);
            end
        end
        req_valid = 1'b0;
        check("bp_accepted", accepted, RSP_DEPTH);
        check("bp_ready_low", req_ready, 0);
        check("bp_rsp_held", {rsp_valid, rsp_tag, rsp_result}, {1'b1, 4'd0, 32'd100});
        rsp_ready = 1'b1;
        #1;
        check("bp_ready_not_comb", req_ready, 0);
        cycles(1);
        check("bp_ready_after_pop", req_ready, 1);
        wait_log(base + RSP_DEPTH);
        for (int i = 0; i < RSP_DEPTH; i++) begin
            chk_log(base + i, 32'd100 + 32'(i), TAG_W'(i), 1'b0);
        end

        // Reset with two responses queued and two in flight.
        cycles(2);
        rsp_ready = 1'b0;
        send(CMD_ADD, 32'd1, 32'd2, 4'd1);
        send(CMD_ADD, 32'd3, 32'd4, 4'd2);
        send(CMD_ADD, 32'd5, 32'd6, 4'd3);
        send(CMD_ADD, 32'd7, 32'd8, 4'd4);
        req_valid = 1'b0;
        check("pre_reset_valid", rsp_valid, 1);
        reset_n = 1'b0;
        #1;
        check("async_rsp_valid", rsp_valid, 0);
        check("async_alu_reset", alu_reset, 1);
        cycles(2);
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        base = log_q.size();
        send(CMD_ADD, 32'd1, 32'd1, 4'd5);
        req_valid = 1'b0;
        wait_log(base + 1);
        cycles(6);
        check("post_reset_log", log_q.size(), base + 1);
        chk_log(base, 32'd2, 4'd5, 1'b0);

        // Randomized traffic under random backpressure.
        req_valid = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!req_valid || acc) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_cmd   = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
                req_in1   = $urandom;
                req_in2   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                req_tag   = TAG_W'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            acc = req_valid && req_ready;
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && model_q.size() != 0; i++) begin
            cycles(1);
        end
        check("final_drained", model_q.size(), 0);
        check("final_rsp_valid", rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
